// File: rtl/cas_pkg.sv
// cas_pkg: shared FSM state type, default element width and bubble-sort length helper.
package cas_pkg;
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} cas_sort_state_t;
  localparam int SNG_WIDTH_DEF = 8;
  function automatic int sort_len(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

// File: rtl/cas.sv
// cas: compare-exchange datapath; swap is the borrow of a-b, so equal values never swap.
module cas #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         swap
);
  logic [W:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
  assign swap = diff[W];
  assign hi = swap ? b : a;
  assign lo = swap ? a : b;
endmodule

// File: rtl/cas_sort_ctrl.sv
// cas_sort_ctrl: load/sort/drain descending sorter sharing one cas unit over a register file.
// Optional swap_cnt port and counter enabled by defining CAS_SORT_SWAP_CNT_EN.
module cas_sort_ctrl
  import cas_pkg::*;
#(
  parameter int SNG_WIDTH = SNG_WIDTH_DEF,
  parameter int NUM_ELEMS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SNG_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef CAS_SORT_SWAP_CNT_EN
  ,
  output logic [7:0]           swap_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(NUM_ELEMS - 1);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_ELEMS - 2);
  cas_sort_state_t state, next;
  logic [SNG_WIDTH-1:0] mem [NUM_ELEMS];
  logic [IDX_W-1:0] wr_idx, rd_idx, i, pass;
  logic [SNG_WIDTH-1:0] hi, lo;
  logic swap, load_beat, load_done, pass_end, sort_done, drain_beat, rd_last;
  cas #(.W(SNG_WIDTH)) u_cas (
    .a(mem[i]),
    .b(mem[i + 1'b1]),
    .hi(hi),
    .lo(lo),
    .swap(swap)
  );
  assign in_ready   = state == LOAD;
  assign out_valid  = state == DRAIN;
  assign busy       = state != LOAD;
  assign rd_last    = rd_idx == LAST_W;
  assign out_last   = out_valid && rd_last;
  assign load_beat  = in_ready && in_valid;
  assign load_done  = load_beat && wr_idx == LAST_W;
  assign pass_end   = i == LAST_I - pass;
  assign sort_done  = state == SORT && pass_end && pass == LAST_I;
  assign drain_beat = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= next;
  always_comb begin
    next = state;
    if (load_done) next = SORT;
    if (sort_done) next = DRAIN;
    if (drain_beat && rd_last) next = LOAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ELEMS; k++) mem[k] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      i        <= '0;
      pass     <= '0;
      out_data <= '0;
    end else begin
      if (load_beat) begin
        mem[wr_idx] <= in_data;
        wr_idx <= load_done ? '0 : wr_idx + 1'b1;
      end
      if (state == SORT) begin
        if (swap) begin
          mem[i]        <= hi;
          mem[i + 1'b1] <= lo;
        end
        i <= pass_end ? '0 : i + 1'b1;
        if (pass_end) pass <= sort_done ? '0 : pass + 1'b1;
        // final comparison is always at i=0, so hi is the new mem[0]
        if (sort_done) out_data <= hi;
      end
      if (drain_beat) begin
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
        if (!rd_last) out_data <= mem[rd_idx + 1'b1];
      end
    end
  end
`ifdef CAS_SORT_SWAP_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) swap_cnt <= '0;
    else if (load_done) swap_cnt <= '0;
    else if (state == SORT && swap && swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_cas_sort_ctrl.sv
// tb_cas_sort_ctrl: directed and random frames checked against a sorted-queue reference model.
module tb_cas_sort_ctrl;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, out_data;
`ifdef CAS_SORT_SWAP_CNT_EN
  logic [7:0] swap_cnt;
`endif
  int checks = 0, passes = 0;
  cas_sort_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
`ifdef CAS_SORT_SWAP_CNT_EN
    , .swap_cnt(swap_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic load(input logic [7:0] v[4], input bit hold);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1;
      in_data = v[k];
      chk("load_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = hold;
    in_data = 8'hAA;
  endtask
  task automatic sort_wait();
    int cnt = 0;
    chk("sort_busy", busy, 1);
    chk("sort_in_ready", in_ready, 0);
    while (!out_valid && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("sort_cycles", cnt, 6);
  endtask
  // mode 0: always ready, 1: alternate 1/0, 2: random
  task automatic drain(input logic [7:0] v[4], input int mode);
    logic [7:0] q[$];
    int inv = 0, k = 0, t = 0;
    for (int a = 0; a < 4; a++) begin
      q.push_back(v[a]);
      for (int b = a + 1; b < 4; b++) if (v[a] < v[b]) inv++;
    end
    q.rsort();
    while (k < 4 && t < 100) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'((t % 2) == 0) : 1'($urandom_range(0, 1));
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, q[k]);
      chk("out_last", out_last, k == 3);
`ifdef CAS_SORT_SWAP_CNT_EN
      chk("swap_cnt", swap_cnt, inv);
`endif
      if (out_ready) k++;
      t++;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 0;
    chk("drain_beats", k, 4);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask
  task automatic frame(input logic [7:0] v[4], input int mode, input bit hold);
    load(v, hold);
    sort_wait();
    drain(v, mode);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef CAS_SORT_SWAP_CNT_EN
    chk({tag, "_swap_cnt"}, swap_cnt, 0);
`endif
  endtask
  initial begin
    logic [7:0] v[4];
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
    #1 chk_reset("rst");
    @(negedge clk); @(negedge clk);
    rst = 0;
    v = '{3, 200, 7, 7};     frame(v, 0, 0);
    v = '{0, 255, 1, 254};   frame(v, 1, 0);
    v = '{9, 9, 9, 9};       frame(v, 0, 0);
    v = '{50, 60, 70, 80};
    load(v, 0);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 chk_reset("midsort");
    @(negedge clk);
    rst = 0;
    v = '{1, 2, 3, 4};       frame(v, 0, 0);
    v = '{10, 30, 20, 40};   frame(v, 2, 1);
    v = '{5, 1, 4, 2};       frame(v, 0, 0);
    v = '{8, 6, 7, 9};       frame(v, 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) v[k] = 8'($urandom);
      if (r == 0) v[2] = v[1];
      frame(v, 2, r[0]);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
